regfile_mp_sb: RTL and testbench

- Parametrised multi-read-port register file with per-byte write mask, per-byte write-through bypass and a per-register scoreboard (busy bits).
- Next-generation integer/FP register file for the pipelined core; sits between decode/issue and writeback.
- Scoreboard lets issue stall on pending writes without external bookkeeping.
- Optional registered read (RD_LAT=1) for high-frequency builds.

---
 rtl/regfile_mp_sb_if.sv | 39 +++
 rtl/regfile_mp_sb.sv | 122 ++++++++++++
 tb/tb_regfile_mp_sb.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_sb_if.sv
// Bundle of writeback, issue and read-port signals for regfile_mp_sb.
// The master side (issue/writeback logic) drives writes, issues and read
// addresses; the slave side (the register file) returns read data and the
// scoreboard view.
//
// Handshake: there is no valid/ready backpressure. RegWrite and ISSUE act
// as single-cycle valids that are always accepted at the next rising clock
// edge, and read addresses are sampled every cycle. The register file never
// stalls its master.
interface regfile_mp_sb_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
);
  logic                  RegWrite;
  logic [AW-1:0]         W_ADDR;
  logic [XLEN-1:0]       W_DATA;
  logic [XLEN/8-1:0]     W_MASK;
  logic                  W_CLR;
  logic                  ISSUE;
  logic [AW-1:0]         ISSUE_ADDR;
  logic [NRD*AW-1:0]     R_ADDR;
  logic [NRD*XLEN-1:0]   OUT;
  logic [NRD-1:0]        R_BUSY;
  logic [NREGS-1:0]      BUSY;

  modport master (
    output RegWrite, W_ADDR, W_DATA, W_MASK, W_CLR,
    output ISSUE, ISSUE_ADDR, R_ADDR,
    input  OUT, R_BUSY, BUSY
  );

  modport slave (
    input  RegWrite, W_ADDR, W_DATA, W_MASK, W_CLR,
    input  ISSUE, ISSUE_ADDR, R_ADDR,
    output OUT, R_BUSY, BUSY
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with per-byte write mask, per-byte
// write-through bypass on every read port, and a per-register busy
// scoreboard. Reads are combinational (RD_LAT=0) or registered (RD_LAT=1);
// in both cases the same-cycle writeback is merged in lane by lane.
module regfile_mp_sb #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int RD_LAT   = 0,
  parameter int ZERO_REG = 1
) (
  input  logic             CLK,
  input  logic             RST,
  regfile_mp_sb_if.slave   rf_if
);

  localparam int NB = XLEN / 8;

  // Register index r is backed by storage (exists and is not the hardwired zero).
  function automatic logic idx_legal(input int r);
    return (r < NREGS) && !((ZERO_REG != 0) && (r == 0));
  endfunction

  // Runtime address check shared by write, issue and bypass qualification.
  function automatic logic addr_legal(input logic [AW-1:0] a);
    return (32'(a) < 32'(NREGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NREGS-1:0]    busy_q;
  logic [NRD*XLEN-1:0] out_d;
  logic [NRD-1:0]      r_busy_d;
  logic                wr_en;
  logic                clr_en;

  // A write only lands (and only bypasses) when its address is legal.
  assign wr_en  = rf_if.RegWrite && addr_legal(rf_if.W_ADDR);
  // A writeback clear; illegal addresses never match a legal register.
  assign clr_en = rf_if.RegWrite && rf_if.W_CLR;

  // Storage: per-lane masked write, full clear on reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      for (int r = 0; r < NREGS; r++) begin
        if (idx_legal(r) && (rf_if.W_ADDR == AW'(r))) begin
          for (int i = 0; i < NB; i++) begin
            if (rf_if.W_MASK[i]) begin
              regs_q[r][8*i +: 8] <= rf_if.W_DATA[8*i +: 8];
            end
          end
        end
      end
    end
  end

  // Scoreboard: issue sets, writeback clear resets, issue wins a tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (!idx_legal(r)) begin
          busy_q[r] <= 1'b0;
        end else if (rf_if.ISSUE && (rf_if.ISSUE_ADDR == AW'(r))) begin
          busy_q[r] <= 1'b1;
        end else if (clr_en && (rf_if.W_ADDR == AW'(r))) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  // Read ports: stored word, overridden lane by lane by the in-flight write,
  // plus the post-writeback busy view of each port's address.
  always_comb begin
    out_d    = '0;
    r_busy_d = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (idx_legal(r) && (rf_if.R_ADDR[AW*k +: AW] == AW'(r))) begin
          out_d[XLEN*k +: XLEN] = regs_q[r];
          r_busy_d[k]           = busy_q[r];
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (wr_en && rf_if.W_MASK[i] &&
            (rf_if.W_ADDR == rf_if.R_ADDR[AW*k +: AW])) begin
          out_d[XLEN*k + 8*i +: 8] = rf_if.W_DATA[8*i +: 8];
        end
      end
      if (clr_en && (rf_if.W_ADDR == rf_if.R_ADDR[AW*k +: AW])) begin
        r_busy_d[k] = 1'b0;
      end
    end
  end

  assign rf_if.R_BUSY = r_busy_d;
  assign rf_if.BUSY   = busy_q;

  generate
    if (RD_LAT == 1) begin : g_rd_reg
      logic [NRD*XLEN-1:0] out_q;
      // Registered read: capture the bypassed read data every edge.
      always_ff @(posedge CLK) begin
        if (RST) begin
          out_q <= '0;
        end else begin
          out_q <= out_d;
        end
      end
      assign rf_if.OUT = out_q;
    end else begin : g_rd_comb
      assign rf_if.OUT = out_d;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: one combinational-read build (NRD=2) and
// one registered-read build (NRD=4) share the same write/issue stimulus.
module tb_regfile_mp_sb;

  logic        clk;
  logic        rst;
  logic        reg_write;
  logic [4:0]  w_addr;
  logic [63:0] w_data;
  logic [7:0]  w_mask;
  logic        w_clr;
  logic        issue;
  logic [4:0]  issue_addr;
  logic [9:0]  r_addr0;
  logic [19:0] r_addr1;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] R1_VAL  = 64'h1357_9BDF_2468_ACE0;
  localparam logic [63:0] R2_VAL  = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] R3_MRG  = 64'hAA11_2222_3333_44DD;
  localparam logic [63:0] R4_VAL  = 64'h0123_4567_89AB_CDEF;

  regfile_mp_sb_if #(.XLEN(64), .NREGS(32), .AW(5), .NRD(2)) bus0 ();
  regfile_mp_sb_if #(.XLEN(64), .NREGS(32), .AW(5), .NRD(4)) bus1 ();

  assign bus0.RegWrite   = reg_write;
  assign bus0.W_ADDR     = w_addr;
  assign bus0.W_DATA     = w_data;
  assign bus0.W_MASK     = w_mask;
  assign bus0.W_CLR      = w_clr;
  assign bus0.ISSUE      = issue;
  assign bus0.ISSUE_ADDR = issue_addr;
  assign bus0.R_ADDR     = r_addr0;

  assign bus1.RegWrite   = reg_write;
  assign bus1.W_ADDR     = w_addr;
  assign bus1.W_DATA     = w_data;
  assign bus1.W_MASK     = w_mask;
  assign bus1.W_CLR      = w_clr;
  assign bus1.ISSUE      = issue;
  assign bus1.ISSUE_ADDR = issue_addr;
  assign bus1.R_ADDR     = r_addr1;

  regfile_mp_sb #(.XLEN(64), .NREGS(32), .AW(5), .NRD(2), .RD_LAT(0), .ZERO_REG(1))
    dut0 (.CLK(clk), .RST(rst), .rf_if(bus0.slave));

  regfile_mp_sb #(.XLEN(64), .NREGS(32), .AW(5), .NRD(4), .RD_LAT(1), .ZERO_REG(1))
    dut1 (.CLK(clk), .RST(rst), .rf_if(bus1.slave));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write  = 1'b0;
    w_clr      = 1'b0;
    issue      = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d,
                    input logic [7:0] m, input logic clr);
    reg_write = 1'b1;
    w_addr    = a;
    w_data    = d;
    w_mask    = m;
    w_clr     = clr;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    w_addr = '0; w_data = '0; w_mask = '0; issue_addr = '0;
    r_addr0 = '0; r_addr1 = '0;
    tick();
    tick();
    chk("init_busy0", bus0.BUSY, 32'h0);
    rst = 1'b0;

    // Preload r5 and mark it busy, then reset over it.
    wr(5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
    issue = 1'b1; issue_addr = 5'd5;
    tick();
    idle();
    r_addr0 = {5'd0, 5'd5};
    r_addr1 = {15'd0, 5'd5};
    #1;
    chk("pre_rst_r5", bus0.OUT[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pre_rst_busy5", bus0.BUSY[5], 1'b1);
    rst = 1'b1;
    wr(5'd5, 64'h1234, 8'hFF, 1'b0);
    issue = 1'b1; issue_addr = 5'd6;
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_out0", bus0.OUT[63:0], 64'h0);
    chk("rst_busy0", bus0.BUSY, 32'h0);
    chk("rst_busy1", bus1.BUSY, 32'h0);
    chk("rst_out1", bus1.OUT, 256'h0);
    tick();
    chk("rst_out1_reg", bus1.OUT, 256'h0);

    // Masked write with per-byte bypass.
    wr(5'd4, R4_VAL, 8'hFF, 1'b0);
    tick();
    wr(5'd3, 64'h1111_2222_3333_4444, 8'hFF, 1'b0);
    tick();
    wr(5'd3, 64'hAAAA_BBBB_CCCC_DDDD, 8'h81, 1'b0);
    r_addr0 = {5'd4, 5'd3};
    #1;
    chk("bypass_p0", bus0.OUT[63:0], R3_MRG);
    chk("bypass_p1", bus0.OUT[127:64], R4_VAL);
    tick();
    idle();
    #1;
    chk("stored_r3", bus0.OUT[63:0], R3_MRG);

    // Zero register: writes, bypass and issue are all ignored.
    wr(5'd0, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
    r_addr0 = {5'd0, 5'd0};
    #1;
    chk("zero_bypass", bus0.OUT, 128'h0);
    tick();
    idle();
    issue = 1'b1; issue_addr = 5'd0;
    tick();
    idle();
    #1;
    chk("zero_read", bus0.OUT, 128'h0);
    chk("zero_busy0", bus0.BUSY, 32'h0);
    chk("zero_busy1", bus1.BUSY, 32'h0);

    // Scoreboard: issue, same-cycle unblock, clear, issue-wins tie.
    issue = 1'b1; issue_addr = 5'd7;
    tick();
    idle();
    r_addr0 = {5'd7, 5'd3};
    #1;
    chk("sb_busy7", bus0.BUSY[7], 1'b1);
    chk("sb_rbusy", bus0.R_BUSY, 2'b10);
    wr(5'd7, 64'h77, 8'hFF, 1'b1);
    #1;
    chk("sb_rbusy_clr", bus0.R_BUSY, 2'b00);
    chk("sb_busy7_hold", bus0.BUSY[7], 1'b1);
    tick();
    idle();
    #1;
    chk("sb_busy_clr", bus0.BUSY, 32'h0);
    chk("sb_r7_data", bus0.OUT[127:64], 64'h77);
    issue = 1'b1; issue_addr = 5'd7;
    tick();
    idle();
    issue = 1'b1; issue_addr = 5'd7;
    wr(5'd7, 64'h88, 8'hFF, 1'b1);
    tick();
    idle();
    #1;
    chk("sb_issue_wins", bus0.BUSY, 32'h0000_0080);
    chk("sb_issue_wins_rb", bus0.R_BUSY, 2'b10);

    // Registered read, four ports, bypass of a same-cycle full write.
    wr(5'd1, R1_VAL, 8'hFF, 1'b0);
    tick();
    wr(5'd2, R2_VAL, 8'hFF, 1'b0);
    r_addr1 = {5'd0, 5'd2, 5'd1, 5'd1};
    tick();
    idle();
    #1;
    chk("lat1_p0", bus1.OUT[63:0], R1_VAL);
    chk("lat1_p1", bus1.OUT[127:64], R1_VAL);
    chk("lat1_p2", bus1.OUT[191:128], R2_VAL);
    chk("lat1_p3", bus1.OUT[255:192], 64'h0);
    r_addr1 = {5'd0, 5'd2, 5'd1, 5'd3};
    r_addr0 = {5'd7, 5'd2};
    #1;
    chk("lat1_hold", bus1.OUT[63:0], R1_VAL);
    chk("comb_r2", bus0.OUT[63:0], R2_VAL);
    tick();
    chk("lat1_next", bus1.OUT[63:0], R3_MRG);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
